ex_stage_md: RTL

Parametrised execute stage for the MIPS pipeline, sitting between ID/EX and EX/MEM pipeline registers. It extends the logic/shift execute path with add/sub/compare, HI/LO move operations, a single-cycle multiplier and an iterative multi-cycle divider. The divider raises a stall request towards the pipeline controller until its result is committed to HI/LO.

---
 rtl/ex_stage_md_pkg.sv | 39 +++
 rtl/ex_stage_md_div_iter.sv | 75 +++++++
 rtl/ex_stage_md.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ex_stage_md_pkg.sv
// ex_stage_md_pkg: aluop/alusel codes and divider state encoding shared by the execute stage.
package ex_stage_md_pkg;

    localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
    localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
    localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
    localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
    localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
    localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
    localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ex_stage_md_div_iter.sv
// div_iter: radix-2 restoring divider, one quotient bit per cycle, with abort and signed mode.
module div_iter
    import ex_stage_md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            abort,
    input  logic            start,
    input  logic            sign_sel,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int CW = $clog2(XLEN);

    div_state_e      state, state_nx;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] r, q, d, a_mag, b_mag, r_nx, q_nx;
    logic [XLEN:0]   tmp, diff;
    logic            a_neg, b_neg, neg_q, neg_r, ge;

    assign a_neg = sign_sel & dividend[XLEN-1];
    assign b_neg = sign_sel & divisor[XLEN-1];
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor : divisor;

    // no borrow out of the trial subtraction means the shifted remainder covers the divisor
    assign tmp  = {r, q[XLEN-1]};
    assign diff = tmp - {1'b0, d};
    assign ge   = ~diff[XLEN];
    assign r_nx = ge ? diff[XLEN-1:0] : tmp[XLEN-1:0];
    assign q_nx = {q[XLEN-2:0], ge};

    always_comb begin
        state_nx = state;
        case (state)
            DIV_IDLE: state_nx = start ? DIV_BUSY : DIV_IDLE;
            DIV_BUSY: state_nx = (cnt == CW'(XLEN - 1)) ? DIV_DONE : DIV_BUSY;
            DIV_DONE: state_nx = DIV_IDLE;
            default:  state_nx = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            state <= DIV_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == DIV_IDLE && start) begin
                r     <= '0;
                q     <= a_mag;
                d     <= b_mag;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                cnt   <= '0;
            end else if (state == DIV_BUSY) begin
                r   <= r_nx;
                q   <= q_nx;
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign busy      = (state == DIV_IDLE && start) || state == DIV_BUSY;
    assign done      = state == DIV_DONE;
    assign quotient  = neg_q ? -q : q;
    assign remainder = neg_r ? -r : r;

endmodule

// File: rtl/ex_stage_md.sv
// ex_stage_md: MIPS execute stage with logic/shift/arith/move paths, HI/LO, multiplier and iterative divider.
module ex_stage_md
    import ex_stage_md_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RADDR_W  = 5,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                valid_in,
    input  logic [ALUSEL_W-1:0] alusel_in,
    input  logic [ALUOP_W-1:0]  aluop_in,
    input  logic [XLEN-1:0]     reg1_in,
    input  logic [XLEN-1:0]     reg2_in,
    input  logic [RADDR_W-1:0]  w_reg_addr_in,
    input  logic                w_reg_en_in,
    output logic [RADDR_W-1:0]  w_reg_addr_out,
    output logic [XLEN-1:0]     w_reg_data_out,
    output logic                w_reg_en_out,
    output logic                stall_req,
    output logic [XLEN-1:0]     hi_out,
    output logic [XLEN-1:0]     lo_out
);
    localparam int SH_W = $clog2(XLEN);

    logic [XLEN-1:0]   hi, lo, logic_res, shift_res, arith_res, move_res, res, div_q, div_r;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;
    logic [SH_W-1:0]   shamt;
    logic              issue, mul_op, mul_signed, div_op, div_zero, div_start, div_busy, div_done;

    assign issue      = valid_in & ~flush;
    assign shamt      = reg1_in[SH_W-1:0];
    assign mul_op     = aluop_in == EXE_MULT_OP || aluop_in == EXE_MULTU_OP;
    assign mul_signed = aluop_in == EXE_MULT_OP;
    assign div_op     = aluop_in == EXE_DIV_OP || aluop_in == EXE_DIVU_OP;
    assign div_zero   = reg2_in == '0;
    assign div_start  = issue & div_op & ~div_zero;

    // sign-extending to full product width makes one unsigned multiply serve both MULT and MULTU
    assign mul_a = {{XLEN{mul_signed & reg1_in[XLEN-1]}}, reg1_in};
    assign mul_b = {{XLEN{mul_signed & reg2_in[XLEN-1]}}, reg2_in};
    assign prod  = mul_a * mul_b;

    div_iter #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (flush),
        .start     (div_start),
        .sign_sel  (aluop_in == EXE_DIV_OP),
        .dividend  (reg1_in),
        .divisor   (reg2_in),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (div_done && !flush) begin
            hi <= div_r;
            lo <= div_q;
        end else if (issue) begin
            if (mul_op) begin
                hi <= prod[2*XLEN-1:XLEN];
                lo <= prod[XLEN-1:0];
            end else if (aluop_in == EXE_MTHI_OP) begin
                hi <= reg1_in;
            end else if (aluop_in == EXE_MTLO_OP) begin
                lo <= reg1_in;
            end else if (div_op && div_zero) begin
                hi <= reg1_in;
                lo <= '1;
            end
        end
    end

    always_comb begin
        logic_res = '0;
        case (aluop_in)
            EXE_OR_OP:  logic_res = reg1_in | reg2_in;
            EXE_AND_OP: logic_res = reg1_in & reg2_in;
            EXE_NOR_OP: logic_res = ~(reg1_in | reg2_in);
            EXE_XOR_OP: logic_res = reg1_in ^ reg2_in;
            default:    logic_res = '0;
        endcase
    end

    always_comb begin
        shift_res = '0;
        case (aluop_in)
            EXE_SLL_OP: shift_res = reg2_in << shamt;
            EXE_SRL_OP: shift_res = reg2_in >> shamt;
            EXE_SRA_OP: shift_res = XLEN'($signed(reg2_in) >>> shamt);
            default:    shift_res = '0;
        endcase
    end

    always_comb begin
        arith_res = '0;
        case (aluop_in)
            EXE_ADD_OP, EXE_ADDU_OP: arith_res = reg1_in + reg2_in;
            EXE_SUB_OP, EXE_SUBU_OP: arith_res = reg1_in - reg2_in;
            EXE_SLT_OP:  arith_res = {{(XLEN-1){1'b0}}, $signed(reg1_in) < $signed(reg2_in)};
            EXE_SLTU_OP: arith_res = {{(XLEN-1){1'b0}}, reg1_in < reg2_in};
            default:     arith_res = '0;
        endcase
    end

    always_comb begin
        move_res = '0;
        case (aluop_in)
            EXE_MFHI_OP: move_res = hi;
            EXE_MFLO_OP: move_res = lo;
            default:     move_res = '0;
        endcase
    end

    always_comb begin
        res = '0;
        case (alusel_in)
            EXE_RES_LOGIC: res = logic_res;
            EXE_RES_SHIFT: res = shift_res;
            EXE_RES_ARITH: res = arith_res;
            EXE_RES_MOVE:  res = move_res;
            default:       res = '0;
        endcase
    end

    assign stall_req      = rst_n & div_busy;
    assign w_reg_data_out = rst_n ? res : '0;
    assign w_reg_en_out   = rst_n & valid_in & w_reg_en_in & ~stall_req;
    assign w_reg_addr_out = w_reg_addr_in;
    assign hi_out         = hi;
    assign lo_out         = lo;

endmodule
